// File: rtl/cim_comb_rx_pkg.sv
// Shared definitions for the cim_comb_rx receive path.
// Holds the default geometry of the shift chain (word width, words per frame,
// slot-index width, result width, post-difference shift) and the receive FSM
// state encoding used by the top level.
package cim_comb_rx_pkg;

  localparam int dw_def    = 32;  // integrator chain word width
  localparam int nw_def    = 34;  // words per frame (cos/sin for 17 channels)
  localparam int aw_def    = 6;   // slot-index width
  localparam int ow_def    = 24;  // result width
  localparam int shift_def = 8;   // arithmetic right shift after second difference

  typedef enum logic [1:0] {
    st_sync = 2'd0,  // waiting for a gap so we start on a frame boundary
    st_idle = 2'd1,  // between frames
    st_run  = 2'd2   // inside a frame
  } rx_state_e;

endpackage

// File: rtl/cim_comb_slot.sv
// Two-stage comb datapath shared by all word slots of a frame.
// Stage 1 registers the incoming word and its slot index. Stage 2 reads the
// per-slot history (z1 = previous word, z2 = previous first difference), forms
// the second difference, shifts and saturates it, and writes the history back.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_val/in_x/in_slot accepted word, its value and slot index
//   emit                high when results may be presented (chain primed)
//   res_out/res_ch      saturated result and its slot index
//   res_val             result strobe
module cim_comb_slot
  import cim_comb_rx_pkg::*;
#(
  parameter int dw    = dw_def,
  parameter int nw    = nw_def,
  parameter int aw    = aw_def,
  parameter int ow    = ow_def,
  parameter int shift = shift_def
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_val,
  input  logic [dw-1:0] in_x,
  input  logic [aw-1:0] in_slot,
  input  logic          emit,
  output logic [ow-1:0] res_out,
  output logic [aw-1:0] res_ch,
  output logic          res_val
);

  localparam logic signed [dw-1:0] sat_max = dw'((64'd1 << (ow - 1)) - 64'd1);
  localparam logic signed [dw-1:0] sat_min = ~sat_max;

  logic          s1_val;
  logic [dw-1:0] s1_x;
  logic [aw-1:0] s1_k;

  // NOTE: the history is deliberately left without a reset so it maps onto
  // distributed RAM; the priming frames overwrite every slot before use.
  logic [dw-1:0] z1_mem [nw];
  logic [dw-1:0] z2_mem [nw];

  logic [dw-1:0]        d1;
  logic signed [dw-1:0] d2;
  logic signed [dw-1:0] shifted;
  logic [ow-1:0]        sat_val;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    s1_x <= in_x;
    s1_k <= in_slot;
    if (rst) s1_val <= 1'b0;
    else     s1_val <= in_val;
  end

  // Differences wrap modulo 2**dw, matching the integrators upstream.
  assign d1      = s1_x - z1_mem[s1_k];
  assign d2      = d1 - z2_mem[s1_k];
  assign shifted = d2 >>> shift;

  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    sat_val = shifted[ow-1:0];
    if (shifted > sat_max)      sat_val = sat_max[ow-1:0];
    else if (shifted < sat_min) sat_val = sat_min[ow-1:0];
  end

  // A word still in flight when reset hits must not disturb the history.
  always_ff @(posedge clk) begin
    if (s1_val && !rst) begin
      z1_mem[s1_k] <= s1_x;
      z2_mem[s1_k] <= d1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_val <= 1'b0;
      res_out <= '0;
      res_ch  <= '0;
    end else begin
      res_val <= s1_val && emit;
      if (s1_val && emit) begin
        res_out <= sat_val;
        res_ch  <= s1_k;
      end
    end
  end

endmodule

// File: rtl/cim_comb_rx.sv
// Receive end of the cascaded-integrator shift chain.
// Frames the gated word stream into slots, feeds the comb datapath, tracks
// priming (two complete frames since reset), flags short/overlong frames and
// pulses frame_done after each complete frame.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   sr_in, sr_val   serial word stream and its gate
//   res_out/res_ch  signed comb result and slot index; res_val strobe
//   frame_done      one-cycle pulse after the last result of a full frame
//   err_long        sticky: a frame had more than nw words
//   err_short       sticky: a frame ended with fewer than nw words
//   clr_err         clears both sticky errors
module cim_comb_rx
  import cim_comb_rx_pkg::*;
#(
  parameter int dw    = dw_def,
  parameter int nw    = nw_def,
  parameter int aw    = aw_def,
  parameter int ow    = ow_def,
  parameter int shift = shift_def
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [dw-1:0] sr_in,
  input  logic          sr_val,
  output logic [ow-1:0] res_out,
  output logic [aw-1:0] res_ch,
  output logic          res_val,
  output logic          frame_done,
  output logic          err_long,
  output logic          err_short,
  input  logic          clr_err
);

  // One extra counter bit so a count past nw is representable.
  localparam logic [aw:0] nw_c  = (aw + 1)'(nw);
  localparam logic [aw:0] one_c = (aw + 1)'(1);

  rx_state_e   state, state_nxt;
  logic [aw:0] cnt;
  logic        take;
  logic        end_frame;
  logic [aw-1:0] slot;
  logic        full_end, long_end, short_end;
  logic [1:0]  prime_cnt;
  logic        primed;
  logic        fd_pend;

  always_ff @(posedge clk) begin
    if (rst) state <= st_sync;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      st_sync: if (!sr_val) state_nxt = st_idle;
      st_idle: if (sr_val)  state_nxt = st_run;
      st_run:  if (!sr_val) state_nxt = st_idle;
      default: state_nxt = st_sync;
    endcase
  end

  always_comb begin
    take      = 1'b0;
    end_frame = 1'b0;
    slot      = '0;
    case (state)
      st_idle: take = sr_val;
      st_run: begin
        take      = sr_val && (cnt < nw_c);
        end_frame = !sr_val;
        slot      = cnt[aw-1:0];
      end
      default: ;
    endcase
  end

  // cnt holds the number of words received so far; it stops at nw+1, which
  // is enough to tell an overlong frame apart.
  always_ff @(posedge clk) begin
    if (rst)                                         cnt <= '0;
    else if (state == st_idle && sr_val)             cnt <= one_c;
    else if (state == st_run && sr_val && cnt <= nw_c) cnt <= cnt + one_c;
  end

  assign full_end  = end_frame && (cnt == nw_c);
  assign long_end  = end_frame && (cnt > nw_c);
  assign short_end = end_frame && (cnt < nw_c);
  assign primed    = (prime_cnt == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      prime_cnt  <= '0;
      fd_pend    <= 1'b0;
      frame_done <= 1'b0;
      err_long   <= 1'b0;
      err_short  <= 1'b0;
    end else begin
      if (full_end && !primed) prime_cnt <= prime_cnt + 2'd1;
      // The extra stage places frame_done after the last result of the frame.
      fd_pend    <= full_end;
      frame_done <= fd_pend;
      // A new error outranks a simultaneous clear.
      if (long_end)     err_long <= 1'b1;
      else if (clr_err) err_long <= 1'b0;
      if (short_end)    err_short <= 1'b1;
      else if (clr_err) err_short <= 1'b0;
    end
  end

  cim_comb_slot #(
    .dw(dw), .nw(nw), .aw(aw), .ow(ow), .shift(shift)
  ) u_slot (
    .clk    (clk),
    .rst    (rst),
    .in_val (take),
    .in_x   (sr_in),
    .in_slot(slot),
    .emit   (primed),
    .res_out(res_out),
    .res_ch (res_ch),
    .res_val(res_val)
  );

endmodule

// File: tb/tb_cim_comb_rx.sv
// Self-checking bench for cim_comb_rx. Two instances share one stimulus: the
// default shift of 8 and a shift of 0 (to reach saturation). A behavioural
// model computes the expected result for every accepted word and queues it;
// results are popped as the DUT presents them.
module tb_cim_comb_rx;

  localparam int NW = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sr_in;
  logic        sr_val;
  logic        clr_err;

  logic [23:0] res_out, res_out0;
  logic [5:0]  res_ch, res_ch0;
  logic        res_val, res_val0;
  logic        frame_done, frame_done0;
  logic        err_long, err_long0;
  logic        err_short, err_short0;

  always #5 clk = ~clk;

  cim_comb_rx #(.shift(8)) u_dut (
    .clk(clk), .rst(rst), .sr_in(sr_in), .sr_val(sr_val),
    .res_out(res_out), .res_ch(res_ch), .res_val(res_val),
    .frame_done(frame_done), .err_long(err_long), .err_short(err_short),
    .clr_err(clr_err)
  );

  cim_comb_rx #(.shift(0)) u_dut0 (
    .clk(clk), .rst(rst), .sr_in(sr_in), .sr_val(sr_val),
    .res_out(res_out0), .res_ch(res_ch0), .res_val(res_val0),
    .frame_done(frame_done0), .err_long(err_long0), .err_short(err_short0),
    .clr_err(clr_err)
  );

  typedef struct {
    logic [23:0] o8;
    logic [23:0] o0;
    logic [5:0]  ch;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int res_seen = 0;
  int fd_seen  = 0;
  logic [23:0] last_out, last_out0;

  // Behavioural model state
  logic [31:0] z1 [NW];
  logic [31:0] z2 [NW];
  int wcnt   = 0;
  int primes = 0;
  logic [31:0] wbuf [40];

  function automatic logic [23:0] sat_model(input logic [31:0] d2, input int sh);
    longint v;
    v = longint'($signed(d2));
    v = v >>> sh;
    if (v > 64'sd8388607)  v = 64'sd8388607;
    if (v < -64'sd8388608) v = -64'sd8388608;
    return v[23:0];
  endfunction

  task automatic model_word(input logic [31:0] x);
    logic [31:0] d1, d2;
    exp_t e;
    if (wcnt < NW) begin
      d1 = x - z1[wcnt];
      d2 = d1 - z2[wcnt];
      z1[wcnt] = x;
      z2[wcnt] = d1;
      if (primes >= 2) begin
        e.o8 = sat_model(d2, 8);
        e.o0 = sat_model(d2, 0);
        e.ch = 6'(wcnt);
        sb_q.push_back(e);
      end
    end
    wcnt++;
  endtask

  task automatic model_end();
    if (wcnt == NW && primes < 2) primes++;
    wcnt = 0;
  endtask

  // Scoreboard side: runs once per cycle, away from the active edge.
  task automatic sb_monitor();
    exp_t e;
    if (res_val || res_val0) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_res_val ch=%0d val=%b val0=%b", res_ch, res_val, res_val0);
      end else begin
        e = sb_q.pop_front();
        res_seen++;
        last_out  = res_out;
        last_out0 = res_out0;
        if (res_val !== 1'b1 || res_val0 !== 1'b1 || res_out !== e.o8 ||
            res_out0 !== e.o0 || res_ch !== e.ch || res_ch0 !== e.ch) begin
          n_fail++;
          $display("FAIL result got out=%h out0=%h ch=%0d ch0=%0d exp out=%h out0=%h ch=%0d",
                   res_out, res_out0, res_ch, res_ch0, e.o8, e.o0, e.ch);
        end
      end
    end
    if (frame_done) fd_seen++;
  endtask

  task automatic cycle(input logic v, input logic [31:0] x);
    sr_val = v;
    sr_in  = x;
    @(negedge clk);
    sb_monitor();
  endtask

  task automatic send_words(input int n, input bit clr_at_end);
    for (int k = 0; k < n; k++) begin
      model_word(wbuf[k]);
      cycle(1'b1, wbuf[k]);
    end
    model_end();
    clr_err = clr_at_end;
    cycle(1'b0, 32'd0);
    clr_err = 1'b0;
    cycle(1'b0, 32'd0);
    cycle(1'b0, 32'd0);
  endtask

  task automatic send_counting_frames(input int first_f, input int nf);
    for (int f = first_f; f < first_f + nf; f++) begin
      for (int k = 0; k < NW; k++) wbuf[k] = 32'(1000 * f + k);
      send_words(NW, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sr_val = 1'b0; sr_in = '0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({res_val, res_out, res_ch, frame_done, err_long, err_short} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got val=%b out=%h ch=%0d fd=%b el=%b es=%b exp all 0",
               res_val, res_out, res_ch, frame_done, err_long, err_short);
    end
    n_tests++;
    if ({res_val0, res_out0, frame_done0, err_long0, err_short0} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_outputs0 got val=%b out=%h exp 0", res_val0, res_out0);
    end
    rst = 1'b0;
    cycle(1'b0, 32'd0);
  endtask

  task automatic test_priming();
    int rs0, fd0;
    rs0 = res_seen; fd0 = fd_seen;
    send_counting_frames(0, 2);
    n_tests++;
    if (res_seen != rs0 || fd_seen != fd0 + 2) begin
      n_fail++;
      $display("FAIL prime_quiet got results=%0d frame_done=%0d exp 0 and 2",
               res_seen - rs0, fd_seen - fd0);
    end
    send_counting_frames(2, 1);
    n_tests++;
    if (res_seen != rs0 + NW || fd_seen != fd0 + 3) begin
      n_fail++;
      $display("FAIL prime_frame2 got results=%0d frame_done=%0d exp 34 and 3",
               res_seen - rs0, fd_seen - fd0);
    end
    n_tests++;
    if (last_out !== 24'd0) begin
      n_fail++;
      $display("FAIL prime_zero got %h exp 000000", last_out);
    end
  endtask

  task automatic test_ramp();
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < NW; k++) wbuf[k] = 32'(256 * f * f);
      send_words(NW, 1'b0);
    end
    n_tests++;
    if (last_out !== 24'd2 || last_out0 !== 24'd512) begin
      n_fail++;
      $display("FAIL ramp got %h/%h exp 000002/000200", last_out, last_out0);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] seq [3];
    seq[0] = 32'h7FFF_FF00; seq[1] = 32'h8000_0000; seq[2] = 32'h8000_0100;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NW; k++) wbuf[k] = seq[f];
      send_words(NW, 1'b0);
    end
    n_tests++;
    if (last_out !== 24'd0 || last_out0 !== 24'd0 || err_long !== 1'b0 || err_short !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap got %h/%h el=%b es=%b exp 0/0 no error",
               last_out, last_out0, err_long, err_short);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < NW; k++) wbuf[k] = 32'hFFFF_0100;
    send_words(NW, 1'b0);
    n_tests++;
    if (last_out0 !== 24'h7FFFFF || last_out !== 24'h7FFEFF) begin
      n_fail++;
      $display("FAIL sat_pos got %h/%h exp 7fffff/7ffeff", last_out0, last_out);
    end
    send_words(NW, 1'b0);
    n_tests++;
    if (last_out0 !== 24'h800000 || last_out !== 24'h800100) begin
      n_fail++;
      $display("FAIL sat_neg got %h/%h exp 800000/800100", last_out0, last_out);
    end
  endtask

  task automatic test_errors();
    int rs0, fd0;
    rs0 = res_seen; fd0 = fd_seen;
    for (int k = 0; k < 36; k++) wbuf[k] = 32'(7000 + 3 * k);
    send_words(36, 1'b0);
    n_tests++;
    if (err_long !== 1'b1 || err_short !== 1'b0 || res_seen != rs0 + NW || fd_seen != fd0) begin
      n_fail++;
      $display("FAIL long_frame got el=%b es=%b results=%0d fd=%0d exp 1 0 34 0",
               err_long, err_short, res_seen - rs0, fd_seen - fd0);
    end
    rs0 = res_seen;
    for (int k = 0; k < 30; k++) wbuf[k] = 32'(9000 - 5 * k);
    send_words(30, 1'b0);
    n_tests++;
    if (err_long !== 1'b1 || err_short !== 1'b1 || res_seen != rs0 + 30 || fd_seen != fd0) begin
      n_fail++;
      $display("FAIL short_frame got el=%b es=%b results=%0d fd=%0d exp 1 1 30 0",
               err_long, err_short, res_seen - rs0, fd_seen - fd0);
    end
    clr_err = 1'b1;
    cycle(1'b0, 32'd0);
    clr_err = 1'b0;
    n_tests++;
    if (err_long !== 1'b0 || err_short !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err got el=%b es=%b exp 0 0", err_long, err_short);
    end
    // Short frame ending in the same cycle as clr_err: the error must stick.
    for (int k = 0; k < 20; k++) wbuf[k] = 32'(4000 + k);
    send_words(20, 1'b1);
    n_tests++;
    if (err_short !== 1'b1 || err_long !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_vs_err got es=%b el=%b exp 1 0", err_short, err_long);
    end
  endtask

  task automatic test_reset_mid();
    int rs0, fd0;
    for (int k = 0; k < 10; k++) begin
      model_word(32'(5000 + k));
      cycle(1'b1, 32'(5000 + k));
    end
    rst = 1'b1;
    cycle(1'b1, 32'd5010);
    // Only the word still in the pipeline should remain unseen.
    n_tests++;
    if (sb_q.size() != 1) begin
      n_fail++;
      $display("FAIL flush_q got pending=%0d exp 1", sb_q.size());
    end
    sb_q.delete();
    wcnt = 0;
    primes = 0;
    cycle(1'b1, 32'd5011);
    rst = 1'b0;
    rs0 = res_seen; fd0 = fd_seen;
    repeat (5) cycle(1'b1, 32'd6000);
    repeat (3) cycle(1'b0, 32'd0);
    n_tests++;
    if (res_seen != rs0 || fd_seen != fd0 || err_short !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet got results=%0d fd=%0d es=%b exp 0 0 0",
               res_seen - rs0, fd_seen - fd0, err_short);
    end
    send_counting_frames(0, 2);
    n_tests++;
    if (res_seen != rs0 || fd_seen != fd0 + 2) begin
      n_fail++;
      $display("FAIL reprime_quiet got results=%0d fd=%0d exp 0 2",
               res_seen - rs0, fd_seen - fd0);
    end
    send_counting_frames(2, 1);
    n_tests++;
    if (res_seen != rs0 + NW || fd_seen != fd0 + 3 || last_out !== 24'd0) begin
      n_fail++;
      $display("FAIL reprime_frame got results=%0d fd=%0d out=%h exp 34 3 000000",
               res_seen - rs0, fd_seen - fd0, last_out);
    end
  endtask

  initial begin
    test_reset();
    test_priming();
    test_ramp();
    test_wrap();
    test_saturation();
    test_errors();
    test_reset_mid();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got pending=%0d exp 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
